// File: rtl/encoder_pkg.sv
// Shared types and helpers for the sequential priority encoder.
// Optional build macro: ENCODER_PRIO_HIGH_EN (reverses selection priority in prio_pick).
package encoder_pkg;

    // Controller states: IDLE waits for a capture, EMIT drains the pending vector.
    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_e;

    // Default request width and matching code width.
    localparam int N_DEF = 4;
    localparam int W_DEF = 2;

    // Widest vector the helper below accepts; callers zero-extend into it.
    localparam int MAX_N = 64;

    // True when exactly one bit of v is set (v != 0 and v is a power of two).
    function automatic logic popcount_is_one(input logic [MAX_N-1:0] v);
        return (v != '0) && ((v & (v - MAX_N'(1))) == '0);
    endfunction

endpackage

// File: rtl/prio_pick.sv
// Combinational selector: picks one set bit of the pending vector and returns
// its binary index plus a one-hot mask used to clear that bit on transfer.
// Default order is lowest index first; with ENCODER_PRIO_HIGH_EN defined the
// highest index is picked first. An all-zero input yields code 0 and no mask.
module prio_pick
    import encoder_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int W = W_DEF
) (
    input  logic [N-1:0] pending_i,
    output logic [W-1:0] code_o,
    output logic [N-1:0] clr_mask_o
);

    // Scan the vector so that the last match written is the winning bit.
    always_comb begin
        code_o     = '0;
        clr_mask_o = '0;
`ifdef ENCODER_PRIO_HIGH_EN
        for (int i = 0; i < N; i++) begin
            if (pending_i[i]) begin
                code_o = W'(i);
            end
        end
`else
        for (int i = N - 1; i >= 0; i--) begin
            if (pending_i[i]) begin
                code_o = W'(i);
            end
        end
`endif
        if (pending_i != '0) begin
            clr_mask_o[code_o] = 1'b1;
        end
    end

endmodule

// File: rtl/prio_encoder_seq.sv
// Sequential priority encoder: captures a multi-hot request vector in IDLE and
// emits the index of each set bit, one per valid/ready transfer.
// Optional build macro: ENCODER_PRIO_HIGH_EN (highest index emitted first).
//
// Handshake: a code transfers on a rising edge where out_valid && out_ready.
// out_valid, code and last come only from registered state, so they stay
// stable while out_ready is low and never depend combinationally on inputs.
// busy mirrors the FSM state (1 = EMIT) and doubles as its observation point.
module prio_encoder_seq
    import encoder_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int W = W_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] d,
    input  logic         en,
    input  logic         out_ready,
    output logic [W-1:0] code,
    output logic         out_valid,
    output logic         last,
    output logic         busy,
    output logic         miss
);

    state_e         state_q, state_d;
    logic [N-1:0]   pending_q, pending_d;
    logic           miss_q, miss_d;

    logic [W-1:0]   pick_code;
    logic [N-1:0]   pick_clr;
    logic [MAX_N-1:0] pending_ext;
    logic           pending_last;
    logic           req;
    logic           xfer;

    prio_pick #(
        .N (N),
        .W (W)
    ) u_pick (
        .pending_i  (pending_q),
        .code_o     (pick_code),
        .clr_mask_o (pick_clr)
    );

    assign pending_ext  = MAX_N'(pending_q);
    assign pending_last = popcount_is_one(pending_ext);
    assign req          = en && (d != '0);
    assign xfer         = (state_q == EMIT) && out_ready;

    // Next-state logic: capture in IDLE, clear the picked bit on each transfer.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        miss_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    pending_d = d;
                    state_d   = EMIT;
                end
            end
            EMIT: begin
                // Requests while emitting are dropped, never merged.
                miss_d = req;
                if (xfer) begin
                    pending_d = pending_q & ~pick_clr;
                    if (pending_last) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                pending_d = '0;
            end
        endcase
    end

    // State, pending vector and miss pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pending_q <= '0;
            miss_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            miss_q    <= miss_d;
        end
    end

    // Output decode from registered state only.
    always_comb begin
        out_valid = 1'b0;
        busy      = 1'b0;
        code      = '0;
        last      = 1'b0;
        if (state_q == EMIT) begin
            out_valid = 1'b1;
            busy      = 1'b1;
            code      = pick_code;
            last      = pending_last;
        end
        miss = miss_q;
    end

endmodule

// File: tb/tb_prio_encoder_seq.sv
// Self-checking bench for prio_encoder_seq. The reference model holds the
// expected codes as a queue filled from each captured vector in emission order.
// Optional build macro: ENCODER_PRIO_HIGH_EN (model emits highest index first).
module tb_prio_encoder_seq;

    localparam int N = 4;
    localparam int W = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] d = '0;
    logic         en = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] code;
    logic         out_valid;
    logic         last;
    logic         busy;
    logic         miss;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    logic [W-1:0] exp_q[$];
    logic         exp_miss = 1'b0;

    always #5 clk = ~clk;

    prio_encoder_seq #(
        .N (N),
        .W (W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .d         (d),
        .en        (en),
        .out_ready (out_ready),
        .code      (code),
        .out_valid (out_valid),
        .last      (last),
        .busy      (busy),
        .miss      (miss)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Queue the set bits of v in the order they should be emitted.
    task automatic model_load(input logic [N-1:0] v);
`ifdef ENCODER_PRIO_HIGH_EN
        for (int i = N - 1; i >= 0; i--) if (v[i]) exp_q.push_back(W'(i));
`else
        for (int i = 0; i < N; i++) if (v[i]) exp_q.push_back(W'(i));
`endif
    endtask

    task automatic check_outputs(input string tag);
        logic         e_active;
        logic [W-1:0] e_code;
        logic         e_last;
        e_active = (exp_q.size() > 0);
        e_code   = e_active ? exp_q[0] : '0;
        e_last   = (exp_q.size() == 1);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(e_active));
        chk({tag, ".busy"},      32'(busy),      32'(e_active));
        chk({tag, ".code"},      32'(code),      32'(e_code));
        chk({tag, ".last"},      32'(last),      32'(e_last));
        chk({tag, ".miss"},      32'(miss),      32'(exp_miss));
    endtask

    // One clock cycle: check, drive inputs, advance model over the rising edge.
    task automatic cycle(input logic en_v, input logic [N-1:0] d_v, input logic rdy_v,
                         input string tag);
        check_outputs(tag);
        en        = en_v;
        d         = d_v;
        out_ready = rdy_v;
        @(posedge clk);
        if (exp_q.size() > 0) begin
            exp_miss = en_v && (d_v != '0);
            if (rdy_v) void'(exp_q.pop_front());
        end else begin
            exp_miss = 1'b0;
            if (en_v && (d_v != '0)) model_load(d_v);
        end
        @(negedge clk);
    endtask

    task automatic drain(input string tag);
        repeat (6) cycle(1'b0, '0, 1'b1, tag);
    endtask

    initial begin
        @(negedge clk);
        // Reset state while held.
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.busy",      32'(busy),      32'd0);
        chk("rst.code",      32'(code),      32'd0);
        chk("rst.last",      32'(last),      32'd0);
        chk("rst.miss",      32'(miss),      32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: en=0 with d all ones is ignored.
        repeat (5) cycle(1'b0, 4'b1111, 1'b1, "t1");

        // 2: two-bit burst with out_ready held.
        cycle(1'b1, 4'b1010, 1'b1, "t2_cap");
        drain("t2");

        // 3: back-pressure holds the code stable.
        cycle(1'b1, 4'b0111, 1'b0, "t3_cap");
        repeat (3) cycle(1'b0, '0, 1'b0, "t3_hold");
        drain("t3");

        // 4: request during EMIT is missed and never merged.
        cycle(1'b1, 4'b1001, 1'b0, "t4_cap");
        cycle(1'b1, 4'b0100, 1'b0, "t4_req");
        cycle(1'b0, '0, 1'b1, "t4_miss");
        drain("t4");

        // 4b: request on the cycle the last code is accepted is also dropped.
        cycle(1'b1, 4'b0001, 1'b0, "t4b_cap");
        cycle(1'b1, 4'b0010, 1'b1, "t4b_last");
        drain("t4b");

        // 5: asynchronous reset mid-burst discards pending bits.
        cycle(1'b1, 4'b1111, 1'b1, "t5_cap");
        cycle(1'b0, '0, 1'b1, "t5_x0");
        cycle(1'b0, '0, 1'b1, "t5_x1");
        check_outputs("t5_pre");
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rst.out_valid", 32'(out_valid), 32'd0);
        chk("t5_rst.busy",      32'(busy),      32'd0);
        chk("t5_rst.code",      32'(code),      32'd0);
        chk("t5_rst.last",      32'(last),      32'd0);
        chk("t5_rst.miss",      32'(miss),      32'd0);
        exp_q.delete();
        exp_miss = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) cycle(1'b0, '0, 1'b1, "t5_after");

        // 6: zero vector is not a capture; single bit gives one last code.
        cycle(1'b1, 4'b0000, 1'b1, "t6_zero");
        cycle(1'b1, 4'b0000, 1'b1, "t6_zero2");
        cycle(1'b1, 4'b1000, 1'b1, "t6_cap");
        drain("t6");

        // Random traffic against the queue model.
        for (int k = 0; k < 400; k++) begin
            cycle(($urandom_range(0, 2) == 0), N'($urandom_range(0, 15)),
                  ($urandom_range(0, 3) != 0), "rand");
        end
        drain("rand_end");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/prio_encoder_seq.md
Name: prio_encoder_seq

Overview:
Sequential counterpart to the team's 2-to-4 enabled decoder. It captures a multi-hot request vector and emits the binary index of every set bit, one code per handshake, lowest index first. It feeds the lab datapath that drives the decoder, so decoder(code) reproduces each captured bit in turn.

Parameters:
N, 4, width of request vector d (N >= 2, power of two).
W, 2, code width; must equal clog2(N).

Ports:
clk        input   1   rising-edge clock.
rst_n      input   1   asynchronous active-low reset.
d          input   N   request vector, sampled only in IDLE.
en         input   1   capture enable; capture occurs when en=1 and d!=0 in IDLE.
out_ready  input   1   consumer accepts current code.
code       output  W   index of selected pending bit.
out_valid  output  1   code is valid.
last       output  1   current code is the final pending bit.
busy       output  1   pending vector non-empty (state EMIT).
miss       output  1   one-cycle pulse: capture request ignored because busy.

Behaviour:
- Reset: clk and rst_n form the only clock/reset pair; reset is asynchronous, active-low.
  - On rst_n=0, state goes to IDLE immediately and pending is cleared.
  - code=0, out_valid=0, last=0, busy=0, miss=0.
  - Reset mid-emission discards all pending bits; nothing is emitted after release until a new capture.
- State machine: IDLE, EMIT.
  - IDLE, en=1, d!=0: pending<=d, go to EMIT.
  - IDLE, en=1, d==0: stay in IDLE; no miss.
  - IDLE, en=0: stay in IDLE; d is ignored.
  - EMIT: stay until the pending bit being accepted is the only one left (pending becomes 0), then go to IDLE.
- Outputs in EMIT (all derived from registered state/pending only, no combinational input-to-output path):
  - out_valid=1.
  - code = index of lowest set bit of pending.
  - last = (popcount(pending)==1).
  - busy=1.
- Latency: capture at edge T; out_valid=1 and the first code are visible after T, during cycle T+1.
- Handshake:
  - Transfer occurs when out_valid && out_ready at a clock edge.
  - The selected bit is cleared at that edge; the next code appears the following cycle.
  - With out_ready held at 1, throughput is one code per cycle.
  - While out_ready=0, code, last and out_valid are held stable.
- Transfer with last=1: the state returns to IDLE and out_valid/busy drop the next cycle. A capture is possible no earlier than the cycle after that (one idle cycle minimum between bursts).
- miss:
  - Registered: pulses for one cycle after any edge where en=1 and d!=0 while state==EMIT.
  - This includes the cycle in which the last code is accepted; that request is dropped.
  - Consecutive ignored requests produce consecutive miss pulses.
- d bits are never merged into an active pending vector.

Optional Feature:
Macro ENCODER_PRIO_HIGH_EN.
- Defined: selection priority is reversed. code = index of the highest set bit of pending, so emission order is highest index first.
- Undefined: lowest index first, as above.
- Handshake, last, busy and miss behaviour are identical in both builds.

Decomposition:
- Package encoder_pkg:
  - state enum {IDLE, EMIT};
  - default constants N_DEF=4, W_DEF=2;
  - function popcount_is_one.
- Sub-module prio_pick (combinational):
  - inputs: pending vector;
  - outputs: code index and one-hot clear mask;
  - contains the ENCODER_PRIO_HIGH_EN direction switch.
- The top level holds the FSM, the pending register, miss and handshake logic.

Test Plan:
1. Reset and release, en=0, d=4'b1111 for 5 cycles -> out_valid=0, busy=0, miss=0 throughout.
2. IDLE, en=1, d=4'b1010, out_ready=1 -> codes 1 then 3 on consecutive cycles; last=0 then 1; busy drops the cycle after the second transfer. With ENCODER_PRIO_HIGH_EN defined: codes 3 then 1.
3. d=4'b0111 captured, out_ready=0 for 3 cycles -> code=0 held stable with out_valid=1. Then out_ready=1 -> codes 0,1,2 emitted, last only on code 2.
4. During EMIT of 4'b1001, en=1, d=4'b0100 -> miss=1 for exactly one cycle; emitted codes are 0,3 only; code 2 is never emitted.
5. rst_n=0 asserted asynchronously mid-burst of 4'b1111 after code 1 -> outputs zero immediately. After release, no further codes appear until a new capture.
6. IDLE, en=1, d=4'b0000 -> stays in IDLE, out_valid=0, miss=0. Then d=4'b1000 -> single code 3 with last=1.
